vga_fb_arbiter: RTL and testbench



---
 rtl/vga_fb_arbiter_if.sv | 43 ++++
 rtl/vga_fb_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_arbiter_if.sv
// ============================================================================
// Module  : vga_fb_arbiter_if
// Purpose : requester and memory signal bundle for the framebuffer arbiter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 24
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ack;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // The arbiter is the slave of both requesters and drives the memory port.
  modport slave (
    input  disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata,
    output disp_ack, disp_rdata, disp_rvalid, wr_ack,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata,
    input  disp_ack, disp_rdata, disp_rvalid, wr_ack,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
// ============================================================================
// Module  : vga_fb_arbiter
// Purpose : single-port framebuffer arbiter, display bursts with priority and
//           a guaranteed writer slot between bursts. Stats build: ARB_STATS_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module vga_fb_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 24,
  parameter int BURST_LEN = 16,
  parameter int MEM_LAT   = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
`ifdef ARB_STATS_EN
  input  wire logic        stat_clr,
  output logic [15:0]      stat_bursts,
  output logic [15:0]      stat_wr_wait_max,
`endif
  vga_fb_arbiter_if.slave  bus
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                wr_owed_q, wr_owed_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                disp_ack_q, disp_ack_d;
  logic                wr_ack_q, wr_ack_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [MEM_LAT-1:0]  vld_q;
  logic                disp_rvalid_q;
  logic [DATA_W-1:0]   disp_rdata_q;
  logic                rd_issue;

  // Memory outputs are computed one cycle early so every port leaves a flop.
  always_comb begin
    state_d     = state_q;
    wr_owed_d   = wr_owed_q;
    beat_d      = beat_q;
    disp_ack_d  = 1'b0;
    wr_ack_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.wr_req && (wr_owed_q || !bus.disp_req)) begin
          state_d     = S_WRITE;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = bus.wr_addr;
          mem_wdata_d = bus.wr_data;
          wr_ack_d    = 1'b1;
          wr_owed_d   = 1'b0;
        end else if (bus.disp_req) begin
          state_d    = S_BURST;
          mem_en_d   = 1'b1;
          mem_addr_d = bus.disp_addr;
          disp_ack_d = 1'b1;
          beat_d     = '0;
          wr_owed_d  = bus.wr_req;
        end
      end

      S_BURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else begin
          mem_en_d   = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          beat_d     = beat_q + BEAT_W'(1);
        end
      end

      S_WRITE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_owed_q   <= 1'b0;
      beat_q      <= '0;
      disp_ack_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_owed_q   <= wr_owed_d;
      beat_q      <= beat_d;
      disp_ack_q  <= disp_ack_d;
      wr_ack_q    <= wr_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rd_issue = mem_en_q & ~mem_we_q;

  // vld_q[MEM_LAT-1] lines up with the cycle mem_rdata holds the issued word.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q         <= '0;
      disp_rvalid_q <= 1'b0;
      disp_rdata_q  <= '0;
    end else begin
      vld_q[0] <= rd_issue;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      disp_rvalid_q <= vld_q[MEM_LAT-1];
      if (vld_q[MEM_LAT-1]) begin
        disp_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.disp_ack    = disp_ack_q;
  assign bus.disp_rdata  = disp_rdata_q;
  assign bus.disp_rvalid = disp_rvalid_q;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_bursts_q;
  logic [15:0] stat_wait_max_q;
  logic [15:0] wait_cnt_q;

  // wait_cnt_q counts request cycles not yet acknowledged; at the ack cycle
  // it equals the request-to-ack distance.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bursts_q   <= '0;
      stat_wait_max_q <= '0;
      wait_cnt_q      <= '0;
    end else begin
      if (wr_ack_q || !bus.wr_req) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != 16'hFFFF) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end

      if (stat_clr) begin
        stat_bursts_q   <= '0;
        stat_wait_max_q <= '0;
      end else begin
        if (disp_ack_d && (stat_bursts_q != 16'hFFFF)) begin
          stat_bursts_q <= stat_bursts_q + 16'd1;
        end
        if (wr_ack_q && (wait_cnt_q > stat_wait_max_q)) begin
          stat_wait_max_q <= wait_cnt_q;
        end
      end
    end
  end

  assign stat_bursts      = stat_bursts_q;
  assign stat_wr_wait_max = stat_wait_max_q;
`else
  // Statistics counters are not built; arbitration is unaffected.
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
// ============================================================================
// Module  : tb_vga_fb_arbiter
// Purpose : self-checking bench for vga_fb_arbiter (define ARB_STATS_EN to
//           also exercise the statistics counters).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_vga_fb_arbiter;

  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 24;
  localparam int BURST_LEN = 16;
  localparam int MEM_LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_bursts;
  logic [15:0] stat_wr_wait_max;
`endif

  vga_fb_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .BURST_LEN(BURST_LEN),
    .MEM_LAT  (MEM_LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
`ifdef ARB_STATS_EN
    .stat_clr        (stat_clr),
    .stat_bursts     (stat_bursts),
    .stat_wr_wait_max(stat_wr_wait_max),
`endif
    .bus             (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [DATA_W-1:0] tb_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] exp_mem [int];
  logic [DATA_W-1:0] rd_pipe [MEM_LAT];

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return {4'hA, a};
  endfunction

  function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
    if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
    return init_val(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? tb_mem[bus.mem_addr] : '0;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got 0x%0h where none was expected (cycle %0d)", name, act, cyc);
  endtask

  // ---------------- scoreboard ----------------
  logic [ADDR_W-1:0] q_addr [$];
  logic [DATA_W-1:0] q_data [$];
  int                q_issue [$];
  logic [ADDR_W-1:0] last_rd_addr = '0;
  int                last_rd_cyc  = 0;
  int                n_wr_ack     = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_en && !bus.mem_we) begin
        if (q_addr.size() == 0) flag("rd_unexpected", 32'(bus.mem_addr));
        else check("rd_addr", 32'(bus.mem_addr), 32'(q_addr.pop_front()));
        q_issue.push_back(cyc);
        last_rd_addr = bus.mem_addr;
        last_rd_cyc  = cyc;
      end
      if (bus.mem_en && bus.mem_we) check("wr_ack_with_write", 32'(bus.wr_ack), 32'd1);
      if (bus.disp_rvalid) begin
        if (q_data.size() == 0) flag("rvalid_unexpected", 32'(bus.disp_rdata));
        else check("rdata", 32'(bus.disp_rdata), 32'(q_data.pop_front()));
        if (q_issue.size() != 0)
          check("rvalid_latency", 32'(cyc - q_issue.pop_front()), 32'(MEM_LAT + 1));
      end
      if (bus.wr_ack) n_wr_ack++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] x;
    for (int k = 0; k < BURST_LEN; k++) begin
      x = a + ADDR_W'(k);
      q_addr.push_back(x);
      q_data.push_back(exp_rd(x));
    end
  endtask

  task automatic wait_ack(input bit wr, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((wr ? bus.wr_ack : bus.disp_ack) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) flag(wr ? "wr_ack_timeout" : "disp_ack_timeout", 32'(bound));
  endtask

  task automatic drain(input int bound);
    int i;
    i = 0;
    while ((q_addr.size() != 0 || q_data.size() != 0) && i < bound) begin
      @(negedge clk);
      i++;
    end
    if (i >= bound) flag("drain_timeout", 32'(q_data.size()));
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    bit                is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] exp_last;
  } vec_t;

  task automatic do_txn(input vec_t v);
    int t0, at;
    tick();
    t0 = cyc;
    if (v.is_wr) begin
      bus.wr_req  = 1'b1;
      bus.wr_addr = v.addr;
      bus.wr_data = v.data;
      exp_mem[int'(v.addr)] = v.data;
    end else begin
      bus.disp_req  = 1'b1;
      bus.disp_addr = v.addr;
      push_burst(v.addr);
    end
    wait_ack(v.is_wr, 8, at);
    if (at >= 0) begin
      check("grant_latency", 32'(at - t0), 32'd1);
      if (v.is_wr) begin
        check("wr_mem_en", 32'(bus.mem_en), 32'd1);
        check("wr_mem_we", 32'(bus.mem_we), 32'd1);
        check("wr_mem_addr", 32'(bus.mem_addr), 32'(v.addr));
        check("wr_mem_wdata", 32'(bus.mem_wdata), 32'(v.data));
      end
    end
    tick();
    bus.wr_req   = 1'b0;
    bus.disp_req = 1'b0;
    @(negedge clk);
    check("ack_single_pulse", 32'(v.is_wr ? bus.wr_ack : bus.disp_ack), 32'd0);
    drain(64);
    if (!v.is_wr && at >= 0) begin
      check("burst_last_addr", 32'(last_rd_addr), 32'(v.exp_last));
      check("burst_span", 32'(last_rd_cyc - at), 32'(BURST_LEN - 1));
    end
  endtask

  vec_t vecs [8];

  initial begin
    int t0, da, wa, nwr0;
`ifdef ARB_STATS_EN
    int tw;
`endif
    for (int i = 0; i < (1 << ADDR_W); i++) tb_mem[i] = init_val(ADDR_W'(i));
    for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = '0;
    bus.disp_req = 1'b0; bus.disp_addr = '0;
    bus.wr_req   = 1'b0; bus.wr_addr   = '0; bus.wr_data = '0;

    vecs[0] = '{1'b0, 20'h00100, 24'h000000, 20'h0010F};
    vecs[1] = '{1'b1, 20'h00042, 24'hFF8000, 20'h00000};
    vecs[2] = '{1'b0, 20'hFFFF8, 24'h000000, 20'h00007};
    vecs[3] = '{1'b1, 20'hFFFFF, 24'h123456, 20'h00000};
    vecs[4] = '{1'b0, 20'h0003A, 24'h000000, 20'h00049};
    vecs[5] = '{1'b0, 20'hFFFF0, 24'h000000, 20'hFFFFF};
    vecs[6] = '{1'b1, 20'h00000, 24'h00ABCD, 20'h00000};
    vecs[7] = '{1'b0, 20'h00000, 24'h000000, 20'h0000F};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_disp_ack", 32'(bus.disp_ack), 32'd0);
    check("rst_disp_rvalid", 32'(bus.disp_rvalid), 32'd0);
    check("rst_disp_rdata", 32'(bus.disp_rdata), 32'd0);
    check("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    tick();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) do_txn(vecs[i]);
    check("mem_holds_write", 32'(tb_mem[20'h00042]), 32'hFF8000);

    // simultaneous requests held continuously: burst, write, burst, write ...
    tick();
    t0 = cyc;
    bus.disp_req = 1'b1; bus.disp_addr = 20'h00300;
    bus.wr_req   = 1'b1; bus.wr_addr   = 20'h00500; bus.wr_data = 24'h5A0000;
    exp_mem[int'(20'h00500)] = 24'h5A0000;
    push_burst(20'h00300);
    wait_ack(1'b0, 8, da);
    check("sim_disp_first", 32'(da - t0), 32'd1);
    for (int r = 0; r < 3; r++) begin
      wait_ack(1'b1, BURST_LEN + 8, wa);
      check("sim_wr_after_burst", 32'(wa - da), 32'(BURST_LEN + 1));
      tick();
      if (r == 2) begin
        bus.disp_req = 1'b0;
        bus.wr_req   = 1'b0;
      end else begin
        bus.wr_addr = 20'h00500 + ADDR_W'(r + 1);
        bus.wr_data = 24'h5A0000 + DATA_W'(r + 1);
        exp_mem[int'(bus.wr_addr)] = bus.wr_data;
        push_burst(20'h00300);
        wait_ack(1'b0, 8, da);
        check("sim_disp_next", 32'(da - wa), 32'd2);
      end
    end
    drain(64);
    do_txn('{1'b0, 20'h004F8, 24'h000000, 20'h00507});

    // write request raised and dropped inside a burst never gets a grant
    nwr0 = n_wr_ack;
    tick();
    bus.disp_req = 1'b1; bus.disp_addr = 20'h00900;
    push_burst(20'h00900);
    wait_ack(1'b0, 8, da);
    tick();
    bus.disp_req = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = 20'h00777; bus.wr_data = 24'h777777;
    repeat (3) tick();
    bus.wr_req = 1'b0;
    drain(64);
    check("dropped_wr_no_ack", 32'(n_wr_ack - nwr0), 32'd0);
    check("dropped_wr_mem", 32'(tb_mem[20'h00777]), 32'(init_val(20'h00777)));

    // reset during beat 5 of a burst
    tick();
    bus.disp_req = 1'b1; bus.disp_addr = 20'h00700;
    push_burst(20'h00700);
    wait_ack(1'b0, 8, da);
    repeat (5) tick();
    bus.disp_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_addr.delete(); q_data.delete(); q_issue.delete();
    @(negedge clk);
    check("rst_mid_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mid_rvalid", 32'(bus.disp_rvalid), 32'd0);
    check("rst_mid_disp_ack", 32'(bus.disp_ack), 32'd0);
    repeat (8) @(negedge clk);
    do_txn('{1'b0, 20'h00800, 24'h000000, 20'h0080F});

`ifdef ARB_STATS_EN
    tick(); stat_clr = 1'b1;
    tick(); stat_clr = 1'b0;
    @(negedge clk);
    check("stat_bursts_clr0", 32'(stat_bursts), 32'd0);
    for (int k = 0; k < 3; k++)
      do_txn('{1'b0, 20'h00A00 + ADDR_W'(16 * k), 24'h0, 20'h00A0F + ADDR_W'(16 * k)});
    check("stat_bursts_3", 32'(stat_bursts), 32'd3);
    tick();
    bus.disp_req = 1'b1; bus.disp_addr = 20'h00B00;
    push_burst(20'h00B00);
    wait_ack(1'b0, 8, da);
    tick();
    tw = cyc;
    bus.disp_req = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = 20'h00B80; bus.wr_data = 24'h0B0B0B;
    exp_mem[int'(20'h00B80)] = 24'h0B0B0B;
    wait_ack(1'b1, BURST_LEN + 8, wa);
    tick();
    bus.wr_req = 1'b0;
    drain(64);
    check("stat_bursts_4", 32'(stat_bursts), 32'd4);
    check("stat_wr_wait_max", 32'(stat_wr_wait_max), 32'(wa - tw));
    tick(); stat_clr = 1'b1;
    tick(); stat_clr = 1'b0;
    @(negedge clk);
    check("stat_bursts_clr", 32'(stat_bursts), 32'd0);
    check("stat_wait_clr", 32'(stat_wr_wait_max), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
